key_click_decoder: RTL and testbench

//  Consumer of the debounced key interface: classifies the one-cycle press

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_timer.sv | 36 +++
 rtl/key_click_decoder.sv | 117 +++++++++++
 tb/tb_key_click_decoder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing for the key click decoder.
// Timing constants assume a 50 MHz system clock.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HELD,
    LONG,
    WAIT2,
    HELD2
  } key_state_e;

  localparam int CLK_HZ  = 50_000_000;
  localparam int LONG_MS = 1000;
  localparam int GAP_MS  = 300;

  localparam int LONG_CYC_DEF = (CLK_HZ / 1000) * LONG_MS;
  localparam int GAP_CYC_DEF  = (CLK_HZ / 1000) * GAP_MS;

endpackage

// File: rtl/key_timer.sv
// Saturating gesture timer: clear to zero, count while enabled, stop at the terminal value.
// Terminal flag is combinational from the count, so the owner decides on the same cycle.
module key_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign term_o = (cnt_q == term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !term_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_click_decoder.sv
// Classifies debounced press pulses and key level into single, double and long events.
// All outputs registered; each event is a one-cycle pulse the cycle after the deciding edge.
module key_click_decoder
  import key_pkg::*;
#(
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key_press,
  input  logic key_n,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic busy
);

  // LONG_CYC and GAP_CYC must both be >= 2 and fit in CNT_W bits.
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CYC - 1);

  key_state_e state_q, state_d;
  logic       sc_q, sc_d;
  logic       dc_q, dc_d;
  logic       lp_q, lp_d;
  logic       busy_q;

  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_term;
  logic [CNT_W-1:0] tmr_term_val;

  assign tmr_term_val = (state_q == HELD) ? LONG_TERM : GAP_TERM;

  key_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term_val),
    .term_o (tmr_term)
  );

  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    sc_d    = 1'b0;
    dc_d    = 1'b0;
    lp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_press) begin
          state_d = HELD;
          tmr_clr = 1'b1;
        end
      end
      HELD: begin
        // Release takes priority over the long-press terminal.
        if (key_n) begin
          state_d = WAIT2;
          tmr_clr = 1'b1;
        end else if (tmr_term) begin
          lp_d    = 1'b1;
          state_d = LONG;
        end else begin
          tmr_en = 1'b1;
        end
      end
      LONG: begin
        if (key_n) state_d = IDLE;
      end
      WAIT2: begin
        // A second press beats the gap terminal.
        if (key_press) begin
          dc_d    = 1'b1;
          state_d = HELD2;
        end else if (tmr_term) begin
          sc_d    = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      HELD2: begin
        if (key_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q    <= 1'b0;
      dc_q    <= 1'b0;
      lp_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      dc_q    <= dc_d;
      lp_q    <= lp_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign single_click = sc_q;
  assign double_click = dc_q;
  assign long_press   = lp_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with short timing (LONG=100, GAP=40).
module tb_key_click_decoder;

  logic clk = 1'b0;
  logic rst;
  logic key_press;
  logic key_n;
  logic single_click;
  logic double_click;
  logic long_press;
  logic busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int sc_cnt, dc_cnt, lp_cnt, excl_err;
  int sc_cyc, dc_cyc, lp_cyc;

  key_click_decoder #(
    .LONG_CYC (100),
    .GAP_CYC  (40),
    .CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_press    (key_press),
    .key_n        (key_n),
    .single_click (single_click),
    .double_click (double_click),
    .long_press   (long_press),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Inputs applied in cycle cyc; after the edge, outputs seen belong to cycle cyc+1.
  task automatic step(input logic r, input logic p, input logic k);
    rst = r;
    key_press = p;
    key_n = k;
    @(posedge clk);
    #1;
    cyc++;
    if (single_click) begin sc_cnt++; sc_cyc = cyc; end
    if (double_click) begin dc_cnt++; dc_cyc = cyc; end
    if (long_press)   begin lp_cnt++; lp_cyc = cyc; end
    if ($countones({single_click, double_click, long_press}) > 1) excl_err++;
  endtask

  task automatic clear_counts();
    sc_cnt = 0; dc_cnt = 0; lp_cnt = 0; excl_err = 0;
    sc_cyc = -1; dc_cyc = -1; lp_cyc = -1;
  endtask

  task automatic test_reset();
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    n_cmp++; if (single_click !== 1'b0) begin n_bad++; $display("FAIL reset_single: got %b expected 0", single_click); end
    n_cmp++; if (double_click !== 1'b0) begin n_bad++; $display("FAIL reset_double: got %b expected 0", double_click); end
    n_cmp++; if (long_press !== 1'b0) begin n_bad++; $display("FAIL reset_long: got %b expected 0", long_press); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int r;
    clear_counts();
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_hi: got %b expected 1", busy); end
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    r = cyc;
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (sc_cnt !== 1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", sc_cnt); end
    n_cmp++; if (sc_cyc !== r + 41) begin n_bad++; $display("FAIL single_time: got %0d expected %0d", sc_cyc, r + 41); end
    n_cmp++; if (dc_cnt + lp_cnt !== 0) begin n_bad++; $display("FAIL single_other: got %0d expected 0", dc_cnt + lp_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_lo: got %b expected 0", busy); end
  endtask

  task automatic test_double();
    int r;
    clear_counts();
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    r = cyc;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL double_busy_held2: got %b expected 1", busy); end
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (dc_cnt !== 1) begin n_bad++; $display("FAIL double_count: got %0d expected 1", dc_cnt); end
    n_cmp++; if (dc_cyc !== r + 21) begin n_bad++; $display("FAIL double_time: got %0d expected %0d", dc_cyc, r + 21); end
    n_cmp++; if (sc_cnt + lp_cnt !== 0) begin n_bad++; $display("FAIL double_other: got %0d expected 0", sc_cnt + lp_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL double_busy_lo: got %b expected 0", busy); end
  endtask

  task automatic test_long();
    int t0;
    clear_counts();
    t0 = cyc;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 150; i++) step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL long_busy_hi: got %b expected 1", busy); end
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL long_busy_lo: got %b expected 0", busy); end
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (lp_cnt !== 1) begin n_bad++; $display("FAIL long_count: got %0d expected 1", lp_cnt); end
    n_cmp++; if (lp_cyc !== t0 + 101) begin n_bad++; $display("FAIL long_time: got %0d expected %0d", lp_cyc, t0 + 101); end
    n_cmp++; if (sc_cnt + dc_cnt !== 0) begin n_bad++; $display("FAIL long_other: got %0d expected 0", sc_cnt + dc_cnt); end
  endtask

  task automatic test_release_at_long_terminal();
    int r;
    clear_counts();
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 99; i++) step(1'b0, 1'b0, 1'b0);
    r = cyc;
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (lp_cnt !== 0) begin n_bad++; $display("FAIL tie_long_count: got %0d expected 0", lp_cnt); end
    n_cmp++; if (sc_cnt !== 1) begin n_bad++; $display("FAIL tie_single_count: got %0d expected 1", sc_cnt); end
    n_cmp++; if (sc_cyc !== r + 41) begin n_bad++; $display("FAIL tie_single_time: got %0d expected %0d", sc_cyc, r + 41); end
  endtask

  task automatic test_press_at_gap_terminal();
    int r;
    clear_counts();
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    r = cyc;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (dc_cnt !== 1) begin n_bad++; $display("FAIL gaptie_double_count: got %0d expected 1", dc_cnt); end
    n_cmp++; if (dc_cyc !== r + 41) begin n_bad++; $display("FAIL gaptie_double_time: got %0d expected %0d", dc_cyc, r + 41); end
    n_cmp++; if (sc_cnt + lp_cnt !== 0) begin n_bad++; $display("FAIL gaptie_other: got %0d expected 0", sc_cnt + lp_cnt); end
  endtask

  task automatic test_reset_mid_gesture();
    int r;
    clear_counts();
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if ({single_click, double_click, long_press} !== 3'b000) begin
      n_bad++; $display("FAIL midrst_events: got %b expected 000", {single_click, double_click, long_press});
    end
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (sc_cnt !== 0) begin n_bad++; $display("FAIL midrst_no_single: got %0d expected 0", sc_cnt); end
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    r = cyc;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1);
    n_cmp++; if (sc_cnt !== 1) begin n_bad++; $display("FAIL midrst_clean_count: got %0d expected 1", sc_cnt); end
    n_cmp++; if (sc_cyc !== r + 41) begin n_bad++; $display("FAIL midrst_clean_time: got %0d expected %0d", sc_cyc, r + 41); end
    n_cmp++; if (excl_err !== 0) begin n_bad++; $display("FAIL exclusive: got %0d overlaps expected 0", excl_err); end
  endtask

  initial begin
    rst = 1'b1;
    key_press = 1'b0;
    key_n = 1'b1;
    test_reset();
    test_single();
    test_double();
    test_long();
    test_release_at_long_terminal();
    test_press_at_gap_terminal();
    test_reset_mid_gesture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
